instr_fetch_unit: RTL and testbench

- Producer side of the control path: fetches 32-bit LEGv8 instructions from instruction memory and presents the 11-bit opcode and register fields to the decode/control stage.
- Owns the PC and runs a request/acknowledge handshake to instruction memory and a valid/ready handshake to decode.
- For CBZ instructions it stalls until the datapath resolves the branch, then redirects the PC.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for a LEGv8 control path.
// Owns the PC, fetches one 32-bit word at a time over a req/ack memory port,
// hands it to decode over valid/ready, and stalls on CBZ until the datapath
// reports the branch outcome, then redirects the PC.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [31:0]       IMemData,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [31:0]       Instr,
    output logic [10:0]       OPCode,
    output logic [4:0]        Rm,
    output logic [4:0]        Rn,
    output logic [4:0]        Rd,
    output logic [ADDR_W-1:0] PCOut,
    input  logic              BranchValid,
    input  logic              BranchTaken
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RESOLVE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [7:0]        CBZ_OP  = 8'b1011_0100;

    // CBZ displacement: imm19 is a signed word offset, so sign-extend and scale by 4.
    function automatic logic [ADDR_W-1:0] cbz_offset(input logic [18:0] imm19);
        cbz_offset = {{(ADDR_W-21){imm19[18]}}, imm19, 2'b00};
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pcout_q, pcout_d;
    logic [31:0]         instr_q, instr_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                is_cbz_s;
    logic [ADDR_W-1:0]   pc_next_seq_s;
    logic [ADDR_W-1:0]   pc_branch_s;

    assign is_cbz_s      = (instr_q[31:24] == CBZ_OP);
    assign pc_next_seq_s = pcout_q + PC_STEP;
    assign pc_branch_s   = pcout_q + cbz_offset(instr_q[23:5]);

    // Next-state, PC update and capture logic for the fetch sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pcout_d = pcout_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (IMemAck) begin
                    instr_d = IMemData;
                    pcout_d = pc_q;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ISSUE: begin
                if (InstrReady) begin
                    if (is_cbz_s) begin
                        state_d = ST_RESOLVE;
                    end else begin
                        // pc_q still equals pcout_q here; step from the issued address.
                        pc_d    = pc_next_seq_s;
                        state_d = Enable ? ST_REQ : ST_IDLE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RESOLVE: begin
                if (BranchValid) begin
                    if (BranchTaken) begin
                        pc_d = pc_branch_s;
                    end else begin
                        pc_d = pc_next_seq_s;
                    end
                    state_d = Enable ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_RESOLVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are registered copies of the upcoming state so outputs come straight from flops.
    always_comb begin
        req_d   = (state_d == ST_REQ);
        valid_d = (state_d == ST_ISSUE);
    end

    // State, PC and instruction registers; Reset overrides any in-flight handshake.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            pcout_q <= '0;
            instr_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcout_q <= pcout_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign IMemReq    = req_q;
    assign IMemAddr   = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign OPCode     = instr_q[31:21];
    assign Rm         = instr_q[20:16];
    assign Rn         = instr_q[9:5];
    assign Rd         = instr_q[4:0];
    assign PCOut      = pcout_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized
// instruction stream, checked against an instruction-level PC model.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 64;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Enable;
    logic              IMemReq;
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [31:0]       IMemData;
    logic              InstrValid;
    logic              InstrReady;
    logic [31:0]       Instr;
    logic [10:0]       OPCode;
    logic [4:0]        Rm;
    logic [4:0]        Rn;
    logic [4:0]        Rd;
    logic [ADDR_W-1:0] PCOut;
    logic              BranchValid;
    logic              BranchTaken;

    int                vectors     = 0;
    int                miscompares = 0;
    longint            cycle       = 0;
    longint            last_req_cycle = 0;
    longint            req_gap     = 0;
    logic [63:0]       model_pc    = 64'd0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'd0)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Enable     (Enable),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instr      (Instr),
        .OPCode     (OPCode),
        .Rm         (Rm),
        .Rn         (Rn),
        .Rd         (Rd),
        .PCOut      (PCOut),
        .BranchValid(BranchValid),
        .BranchTaken(BranchTaken)
    );

    // Free-running clock, 10 time units per period.
    always #5 Clk = ~Clk;

    task automatic step();
        @(negedge Clk);
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a memory request; an expired bound shows up as a failed check.
    task automatic wait_req();
        int n;
        n = 0;
        while (IMemReq !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {63'd0, IMemReq}, 64'd1);
    endtask

    // Architectural next-PC rule for one retired instruction.
    function automatic logic [63:0] next_pc(input logic [63:0] pc, input logic [31:0] w, input bit taken);
        longint imm;
        if (w[31:24] == 8'hB4 && taken) begin
            imm = longint'(w[23:5]);
            if (imm >= 262144) imm = imm - 524288;
            return pc + 64'(imm * 4);
        end
        return pc + 64'd4;
    endfunction

    // One complete instruction: fetch, issue, and (for CBZ) branch resolution.
    task automatic fetch_one(input logic [31:0] w, input int ack_dly, input int rdy_dly,
                             input int br_dly, input bit taken, input bit drop_en);
        logic [63:0] addr;
        wait_req();
        chk("req_addr", IMemAddr, model_pc);
        addr           = IMemAddr;
        req_gap        = cycle - last_req_cycle;
        last_req_cycle = cycle;
        for (int i = 0; i < ack_dly; i++) begin
            BranchValid = 1'($urandom_range(0, 1));
            step();
            chk("req_hold", {63'd0, IMemReq}, 64'd1);
            chk("addr_hold", IMemAddr, addr);
            chk("no_valid_in_req", {63'd0, InstrValid}, 64'd0);
        end
        BranchValid = 1'b0;
        IMemAck  = 1'b1;
        IMemData = w;
        step();
        IMemAck  = 1'b0;
        IMemData = $urandom;
        chk("valid_rise", {63'd0, InstrValid}, 64'd1);
        chk("req_drop", {63'd0, IMemReq}, 64'd0);
        chk("instr", {32'd0, Instr}, {32'd0, w});
        chk("opcode", {53'd0, OPCode}, {53'd0, w[31:21]});
        chk("rm", {59'd0, Rm}, {59'd0, w[20:16]});
        chk("rn", {59'd0, Rn}, {59'd0, w[9:5]});
        chk("rd", {59'd0, Rd}, {59'd0, w[4:0]});
        chk("pcout", PCOut, model_pc);
        if (drop_en) Enable = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            BranchValid = 1'($urandom_range(0, 1));
            BranchTaken = 1'($urandom_range(0, 1));
            step();
            chk("valid_stall", {63'd0, InstrValid}, 64'd1);
            chk("instr_stall", {32'd0, Instr}, {32'd0, w});
            chk("pcout_stall", PCOut, model_pc);
            chk("no_req_in_issue", {63'd0, IMemReq}, 64'd0);
        end
        BranchValid = 1'b0;
        InstrReady  = 1'b1;
        step();
        InstrReady  = 1'b0;
        chk("valid_fall", {63'd0, InstrValid}, 64'd0);
        if (w[31:24] == 8'hB4) begin
            for (int i = 0; i < br_dly; i++) begin
                chk("no_fetch_resolve", {63'd0, IMemReq}, 64'd0);
                chk("no_valid_resolve", {63'd0, InstrValid}, 64'd0);
                step();
            end
            BranchValid = 1'b1;
            BranchTaken = taken;
            step();
            BranchValid = 1'b0;
            BranchTaken = 1'($urandom_range(0, 1));
        end
        model_pc = next_pc(model_pc, w, taken);
    endtask

    // Unit should sit in IDLE at model_pc, ignore stray acks, and fetch 1 cycle after Enable.
    task automatic park_and_resume(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            chk("park_no_req", {63'd0, IMemReq}, 64'd0);
            chk("park_no_valid", {63'd0, InstrValid}, 64'd0);
            chk("park_pc", IMemAddr, model_pc);
            IMemAck = 1'($urandom_range(0, 1));
            step();
        end
        IMemAck = 1'b0;
        Enable  = 1'b1;
        step();
        chk("resume_latency", {63'd0, IMemReq}, 64'd1);
        chk("resume_addr", IMemAddr, model_pc);
    endtask

    initial begin
        logic [31:0] w;
        bit          is_cbz;
        bit          drop;

        Reset = 1'b1; Enable = 1'b0; IMemAck = 1'b0; IMemData = 32'd0;
        InstrReady = 1'b0; BranchValid = 1'b0; BranchTaken = 1'b0;
        step(); step(); step();
        Reset = 1'b0;
        step();
        chk("rst_req", {63'd0, IMemReq}, 64'd0);
        chk("rst_valid", {63'd0, InstrValid}, 64'd0);
        chk("rst_instr", {32'd0, Instr}, 64'd0);
        chk("rst_pcout", PCOut, 64'd0);
        chk("rst_pc", IMemAddr, 64'd0);

        // Ack with no request outstanding must not load anything.
        IMemAck = 1'b1; IMemData = 32'hFFFF_FFFF;
        step();
        IMemAck = 1'b0;
        chk("idle_ack_valid", {63'd0, InstrValid}, 64'd0);
        chk("idle_ack_instr", {32'd0, Instr}, 64'd0);

        Enable = 1'b1;
        step();
        chk("first_req_latency", {63'd0, IMemReq}, 64'd1);

        // ADD with zero-wait memory and decode.
        fetch_one(32'h8B02_0020, 0, 0, 0, 1'b0, 1'b0);
        chk("add_opcode", {53'd0, OPCode}, {53'd0, 11'b100_0101_1000});
        chk("add_rm", {59'd0, Rm}, 64'd2);
        chk("add_rn", {59'd0, Rn}, 64'd1);
        chk("add_rd", {59'd0, Rd}, 64'd0);
        // Slow memory: 3 wait cycles.
        fetch_one(32'h9100_0421, 3, 0, 0, 1'b0, 1'b0);
        chk("zero_wait_req_gap", 64'(req_gap), 64'd2);
        chk("addr_after_add", PCOut, 64'd4);
        // Decode backpressure for 5 cycles.
        fetch_one(32'hCB03_0041, 0, 5, 0, 1'b0, 1'b0);
        fetch_one(32'hAA01_00A2, 0, 0, 0, 1'b0, 1'b0);
        // CBZ +2 at 0x10, taken.
        fetch_one(32'hB400_0040, 0, 0, 2, 1'b1, 1'b0);
        wait_req();
        chk("cbz_taken_target", IMemAddr, 64'h18);
        // CBZ -2 at 0x18 back to 0x10, then same CBZ not taken.
        fetch_one(32'hB4FF_FFC0, 0, 0, 1, 1'b1, 1'b0);
        fetch_one(32'hB400_0040, 0, 0, 2, 1'b0, 1'b0);
        wait_req();
        chk("cbz_not_taken_target", IMemAddr, 64'h14);
        // Jump to 0x100, then CBZ with imm19 = -1.
        fetch_one(32'hB400_0760, 0, 0, 0, 1'b1, 1'b0);
        fetch_one(32'hB4FF_FFE0, 0, 0, 0, 1'b1, 1'b0);
        wait_req();
        chk("cbz_minus1_target", IMemAddr, 64'hFC);
        // Branch below zero to the top of the address space, then step across the wrap.
        fetch_one(32'hB4FF_F800, 0, 0, 0, 1'b1, 1'b0);
        wait_req();
        chk("wrap_down_target", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one(32'h8B02_0020, 0, 0, 0, 1'b0, 1'b0);
        wait_req();
        chk("wrap_up_target", IMemAddr, 64'h0);

        // Enable dropped during ISSUE: park with PC at the next instruction.
        fetch_one(32'h8B02_0020, 1, 2, 0, 1'b0, 1'b1);
        chk("park_next_pc", IMemAddr, 64'd4);
        park_and_resume(3);

        // Reset on the same edge as Ack: data discarded, back to RESET_PC.
        wait_req();
        Reset = 1'b1; IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
        step();
        Reset = 1'b0; IMemAck = 1'b0; Enable = 1'b0;
        chk("rst_ack_instr", {32'd0, Instr}, 64'd0);
        chk("rst_ack_valid", {63'd0, InstrValid}, 64'd0);
        chk("rst_ack_req", {63'd0, IMemReq}, 64'd0);
        chk("rst_ack_pcout", PCOut, 64'd0);
        model_pc = 64'd0;
        step();
        chk("rst_ack_no_valid_later", {63'd0, InstrValid}, 64'd0);
        park_and_resume(1);

        // Randomized instruction stream.
        for (int k = 0; k < 60; k++) begin
            w      = $urandom;
            is_cbz = ($urandom_range(0, 2) == 0);
            if (is_cbz) begin
                w[31:24] = 8'hB4;
            end else if (w[31:24] == 8'hB4) begin
                w[31:24] = 8'h8B;
            end
            drop = ($urandom_range(0, 7) == 0);
            fetch_one(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), drop);
            if (drop) park_and_resume($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
